// File: rtl/rv32i_fetch.sv
// rv32i instruction fetch: one outstanding strobe/ack request, one-entry skid buffer, redirect/discard handling.
// Optional misaligned-redirect trap output enabled by RV32I_FETCH_MISALIGN_EN.
module rv32i_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_iaddr,
  output logic        o_stb_inst,
  input  logic        i_ack_inst,
  input  logic [31:0] i_inst,
  input  logic        i_change_pc,
  input  logic [31:0] i_next_pc,
  input  logic        i_stall,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_ce
`ifdef RV32I_FETCH_MISALIGN_EN
  ,
  output logic        o_misaligned
`endif
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DISCARD, MISAL} state_t;

  state_t      state;
  logic [31:0] pc, pc_inc, redir_pc;
  logic [31:0] skid_inst, skid_pc;
  logic        skid_vld, consumed, out_free;

  assign pc_inc   = pc + 32'd4;
  assign consumed = o_ce && !i_stall;
  assign out_free = !o_ce || !i_stall;

`ifdef RV32I_FETCH_MISALIGN_EN
  assign redir_pc = i_next_pc;
`else
  logic unused_lo;
  assign unused_lo = ^i_next_pc[1:0];
  assign redir_pc  = {i_next_pc[31:2], 2'b00};
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      pc         <= PC_RESET;
      o_iaddr    <= PC_RESET;
      o_stb_inst <= 1'b0;
      o_ce       <= 1'b0;
      o_inst     <= 32'd0;
      o_pc       <= 32'd0;
      skid_vld   <= 1'b0;
      skid_inst  <= 32'd0;
      skid_pc    <= 32'd0;
`ifdef RV32I_FETCH_MISALIGN_EN
      o_misaligned <= 1'b0;
`endif
    end else if (i_change_pc) begin
      // Redirect flushes the presented instruction even if decode is stalled.
      pc       <= redir_pc;
      o_ce     <= 1'b0;
      skid_vld <= 1'b0;
`ifdef RV32I_FETCH_MISALIGN_EN
      o_misaligned <= 1'b0;
      if (|i_next_pc[1:0]) begin
        o_ce         <= 1'b1;
        o_pc         <= i_next_pc;
        o_inst       <= NOP;
        o_misaligned <= 1'b1;
        o_stb_inst   <= 1'b0;
        state        <= MISAL;
      end else
`endif
      if ((state == REQ || state == DISCARD) && !i_ack_inst) begin
        // Request still in flight: keep strobe/address, drop its data on arrival.
        state <= DISCARD;
      end else begin
        o_iaddr    <= redir_pc;
        o_stb_inst <= 1'b1;
        state      <= REQ;
      end
    end else begin
      if (consumed) begin
        o_ce <= 1'b0;
`ifdef RV32I_FETCH_MISALIGN_EN
        o_misaligned <= 1'b0;
`endif
      end
      case (state)
        IDLE: begin
          o_stb_inst <= 1'b1;
          o_iaddr    <= pc;
          state      <= REQ;
        end
        REQ: begin
          if (i_ack_inst) begin
            pc <= pc_inc;
            if (out_free) begin
              o_inst  <= i_inst;
              o_pc    <= o_iaddr;
              o_ce    <= 1'b1;
              o_iaddr <= pc_inc;
            end else begin
              skid_inst  <= i_inst;
              skid_pc    <= o_iaddr;
              skid_vld   <= 1'b1;
              o_stb_inst <= 1'b0;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (consumed && skid_vld) begin
            o_inst     <= skid_inst;
            o_pc       <= skid_pc;
            o_ce       <= 1'b1;
            skid_vld   <= 1'b0;
            o_stb_inst <= 1'b1;
            o_iaddr    <= pc;
            state      <= REQ;
          end
        end
        DISCARD: begin
          if (i_ack_inst) begin
            o_iaddr <= pc;
            state   <= REQ;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: directed steps plus randomized memory latency, stalls and redirects,
// checked against an expected instruction-stream scoreboard and a bus-stability monitor.
module tb_rv32i_fetch;
  localparam logic [31:0] PCR = 32'h0000_0100;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_ack_inst = 1'b0, i_change_pc = 1'b0, i_stall = 1'b0;
  logic [31:0] i_inst = '0, i_next_pc = '0;
  logic [31:0] o_iaddr, o_inst, o_pc;
  logic        o_stb_inst, o_ce, mis_obs;

  rv32i_fetch #(.PC_RESET(PCR)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_iaddr(o_iaddr), .o_stb_inst(o_stb_inst),
    .i_ack_inst(i_ack_inst), .i_inst(i_inst),
    .i_change_pc(i_change_pc), .i_next_pc(i_next_pc),
    .i_stall(i_stall),
    .o_inst(o_inst), .o_pc(o_pc), .o_ce(o_ce)
`ifdef RV32I_FETCH_MISALIGN_EN
    , .o_misaligned(mis_obs)
`endif
  );
`ifndef RV32I_FETCH_MISALIGN_EN
  assign mis_obs = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0;
  // Reference state: next expected delivered PC, memory latency model, in-flight request tracker.
  logic [31:0] exp_pc = PCR, pend_addr = '0;
  int lat = 0, wcnt = 0, deliveries = 0;
  bit rand_mem = 0, pend = 0, flush_chk = 0, force_ack = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Called on a falling edge: drives inputs for the next rising edge and scores what it will do.
  task automatic step(input bit stall, input bit chg = 0, input logic [31:0] npc = '0);
    bit ack;
    if (flush_chk) check1("flush_ce", o_ce, 1'b0);
    ack = (o_stb_inst && wcnt >= lat) || force_ack;
    if (i_rst) begin
      exp_pc = PCR; pend = 0; wcnt = 0; flush_chk = 0;
    end else begin
      if (o_stb_inst) begin
        if (pend) check("iaddr_stable", o_iaddr, pend_addr);
        if (ack) begin
          pend = 0; wcnt = 0;
          if (rand_mem) lat = int'($urandom_range(0, 3));
        end else begin
          pend = 1; pend_addr = o_iaddr; wcnt++;
        end
      end else begin
        pend = 0; wcnt = 0;
      end
      if (o_ce && !stall) begin
        check("deliv_pc", o_pc, exp_pc);
        check("deliv_inst", o_inst, mis_obs ? NOP : (exp_pc ^ K));
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      if (chg) begin
        exp_pc = npc; flush_chk = (npc[1:0] == 2'b00);
      end else flush_chk = 0;
    end
    i_ack_inst  = ack;
    i_inst      = o_iaddr ^ K;
    i_stall     = stall;
    i_change_pc = chg;
    i_next_pc   = npc;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step(0); step(0);
    i_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r, npc;
    @(negedge i_clk);
    do_reset();
    check1("rst_stb", o_stb_inst, 1'b0);
    check1("rst_ce", o_ce, 1'b0);
    check("rst_iaddr", o_iaddr, PCR);
    check("rst_pc", o_pc, 32'd0);
    check("rst_inst", o_inst, 32'd0);

    // Zero-wait streaming
    lat = 0;
    step(0);
    check1("t1_stb", o_stb_inst, 1'b1);
    check("t1_iaddr", o_iaddr, PCR);
    check1("t1_ce0", o_ce, 1'b0);
    step(0);
    check1("t1_ce", o_ce, 1'b1);
    check("t1_pc0", o_pc, 32'h100);
    check("t1_inst0", o_inst, 32'h100 ^ K);
    step(0); check("t1_pc1", o_pc, 32'h104);
    step(0); check("t1_pc2", o_pc, 32'h108);

    // Ack delayed 3 cycles
    do_reset(); lat = 3;
    step(0);
    for (int i = 0; i < 3; i++) begin
      step(0);
      check("t2_iaddr", o_iaddr, 32'h100);
      check1("t2_ce0", o_ce, 1'b0);
    end
    step(0);
    check1("t2_ce", o_ce, 1'b1);
    check("t2_pc", o_pc, 32'h100);

    // Stall with a new ack: skid capture and release
    do_reset(); lat = 0;
    step(0); step(0); step(0);
    check("t3_pc_pre", o_pc, 32'h104);
    step(1);
    check1("t3_stb_drop", o_stb_inst, 1'b0);
    for (int i = 0; i < 3; i++) step(1);
    check("t3_hold_pc", o_pc, 32'h104);
    check1("t3_hold_ce", o_ce, 1'b1);
    check1("t3_hold_stb", o_stb_inst, 1'b0);
    step(0);
    check("t3_skid_pc", o_pc, 32'h108);
    check1("t3_stb_up", o_stb_inst, 1'b1);
    check("t3_iaddr", o_iaddr, 32'h10C);
    step(0);
    check("t3_next_pc", o_pc, 32'h10C);

    // Redirect while a request is pending with no ack
    lat = 2;
    step(0, 1, 32'h200);
    check1("t4_ce", o_ce, 1'b0);
    check("t4_iaddr_held", o_iaddr, 32'h110);
    step(0); step(0);
    check("t4_iaddr_new", o_iaddr, 32'h200);
    check1("t4_ce_still0", o_ce, 1'b0);
    lat = 0;
    step(0);
    check("t4_pc", o_pc, 32'h200);

    // Redirect coincident with ack
    step(0, 1, 32'h300);
    check("t5_iaddr", o_iaddr, 32'h300);
    step(0);
    check("t5_pc", o_pc, 32'h300);

    // PC wrap
    step(0, 1, 32'hFFFF_FFFC);
    step(0);
    check("t6_pc", o_pc, 32'hFFFF_FFFC);
    check("t6_wrap_iaddr", o_iaddr, 32'h0);
    step(0);
    check("t6_pc0", o_pc, 32'h0);

    // Redirect while holding a skid entry under stall
    step(1);
    check1("t7_stb_drop", o_stb_inst, 1'b0);
    step(1, 1, 32'h500);
    check("t7_iaddr", o_iaddr, 32'h500);
    step(0);
    check("t7_pc", o_pc, 32'h500);

    // Reset mid-request, then an ack while strobe is low
    lat = 3;
    step(0);
    i_rst = 1'b1;
    step(0);
    check1("t8_rst_stb", o_stb_inst, 1'b0);
    check1("t8_rst_ce", o_ce, 1'b0);
    i_rst = 1'b0; force_ack = 1;
    step(0);
    force_ack = 0;
    check1("t8_late_ack_ce", o_ce, 1'b0);
    check("t8_iaddr", o_iaddr, PCR);

`ifdef RV32I_FETCH_MISALIGN_EN
    lat = 0;
    step(0);
    check("t9_pc", o_pc, PCR);
    step(0, 1, 32'h402);
    check1("t9_mis", mis_obs, 1'b1);
    check("t9_mis_pc", o_pc, 32'h402);
    check("t9_mis_inst", o_inst, NOP);
    check1("t9_mis_stb", o_stb_inst, 1'b0);
    step(1); step(0);
    check1("t9_mis_clr", mis_obs, 1'b0);
    check1("t9_stb_low", o_stb_inst, 1'b0);
    step(0, 1, 32'h600);
    check("t9_iaddr", o_iaddr, 32'h600);
`endif

    // Randomized traffic against the stream scoreboard
    do_reset();
    rand_mem = 1; lat = int'($urandom_range(0, 3)); deliveries = 0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom();
      npc = {r[31:2], 2'b00};
      if (r[7:5] == 3'd0) npc = 32'hFFFF_FFF4;
      step(($urandom() % 10) < 3, ($urandom() % 25) == 0, npc);
    end
    checks++;
    assert (deliveries > 200) else begin
      errors++;
      $error("FAIL rand_progress: observed %0d deliveries expected more than 200", deliveries);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
